hamming_error_monitor: RTL
==========================

HAMMING_ERROR_MONITOR -- requirements
Module: hamming_error_monitor

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 32: decoded payload width; ADDR_WIDTH = hamming_address_width(DATA_WIDTH).
REQ-002 SHALL take parameter WORD_ADDR_WIDTH, default 10: memory word address width.
REQ-003 SHALL take parameter CNT_WIDTH, default 16: error counter width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_valid_i  in  1 / in_ready_o  out  1  upstream handshake from decoder stage.
REQ-008 in_addr_i  in  WORD_ADDR_WIDTH / data_i  in  DATA_WIDTH / fault_location_i  in  ADDR_WIDTH / num_errors_i  in  2  decoder word, address, syndrome, error class.
REQ-009 out_valid_o  out  1 / out_ready_i  in  1 / out_data_o  out  DATA_WIDTH / out_addr_o  out  WORD_ADDR_WIDTH / out_err_o  out  1  downstream word; out_err_o = uncorrectable.
REQ-010 scrub_req_o  out  1 / scrub_ack_i  in  1 / scrub_addr_o  out  WORD_ADDR_WIDTH / scrub_data_o  out  DATA_WIDTH  write-back request of corrected word.
REQ-011 threshold_i  in  CNT_WIDTH / irq_o  out  1 / irq_clear_i  in  1  interrupt control.
REQ-012 corr_count_o, uncorr_count_o, scrub_drop_o  out  CNT_WIDTH each; last_fault_loc_o  out  ADDR_WIDTH; last_fault_addr_o  out  WORD_ADDR_WIDTH  statistics.

Function
REQ-013 Transfer SHALL occur when valid and ready are both high on a rising edge.
REQ-014 in_ready_o SHALL equal !out_valid_o || out_ready_i; it SHALL NOT depend on in_valid_i.
REQ-015 Accepted word SHALL appear on out_* the next cycle (latency 1), held stable while out_valid_o && !out_ready_i.
REQ-016 num_errors_i: 0 = clean, 1 = corrected, 2 or 3 = uncorrectable; out_err_o = 1 for 2/3.
REQ-017 Corrected word SHALL increment corr_count_o; uncorrectable SHALL increment uncorr_count_o; both saturate at all-ones.
REQ-018 On any accepted error (class 1-3), last_fault_loc_o/last_fault_addr_o SHALL capture fault_location_i/in_addr_i.
REQ-019 Scrub FSM states IDLE, REQ; IDLE->REQ on acceptance of corrected word, capturing in_addr_i/data_i; REQ->IDLE on scrub_ack_i.
REQ-020 scrub_req_o = (state == REQ), asserted the cycle after acceptance, address/data stable until ack.
REQ-021 Corrected word accepted in REQ without same-cycle ack SHALL be dropped from scrub and increment scrub_drop_o (saturating).
REQ-022 Corrected word accepted in the same cycle as scrub_ack_i SHALL be captured; FSM stays REQ.
REQ-023 Uncorrectable words SHALL never be scrubbed.
REQ-024 irq_o SHALL set (sticky) when any uncorrectable word is accepted, or when corr_count_o increments to >= threshold_i with threshold_i != 0.
REQ-025 irq_clear_i SHALL clear irq_o and all three counters; a same-cycle error event SHALL leave its counter at 1 and re-evaluate irq_o next cycle.

Reset
REQ-026 rst SHALL asynchronously force: out_valid_o 0, out_data_o/out_addr_o/out_err_o 0, FSM IDLE, scrub_req_o 0, scrub_addr_o/scrub_data_o 0, irq_o 0, all counters and last_fault_* 0.
REQ-027 Reset mid-scrub SHALL abandon the request; no request SHALL be reissued after release.
REQ-028 in_ready_o SHALL be 1 in the first cycle after reset release.

Structure
REQ-029 Scrub state enum and error-class constants (ERR_NONE, ERR_CORR, ERR_UNCORR) SHALL live in gray_area_package, beside hamming_address_width.
REQ-030 One sub-module, sat_counter (width parameter, inc, clr, saturating), SHALL be instantiated three times.

Verification
REQ-031 Clean word addr 0x005, data 0xDEADBEEF, out_ready_i 1 -> out next cycle, out_err_o 0, counters 0, no scrub.
REQ-032 num_errors 1, loc 6, addr 0x010 -> corr_count 1, last_fault_loc 6, scrub_req next cycle with addr 0x010; ack -> IDLE.
REQ-033 num_errors 2 -> out_err_o 1, uncorr_count 1, irq_o 1, no scrub_req.
REQ-034 threshold 3, three corrected words, scrub_ack_i held 0 -> corr_count 3, scrub_drop 2, irq_o after third.
REQ-035 out_ready_i 0 for 5 cycles with stream -> in_ready_o 0, out_* stable, no loss or duplication.
REQ-036 rst during REQ, then irq_clear_i coinciding with corrected word -> scrub_req 0 after reset; corr_count 1 after clear.

Source files
------------

// File: rtl/hamming_error_monitor_pkg.sv
// Shared types and constants for the Hamming error monitor: scrub FSM states,
// decoder error classes and the syndrome/fault-location width helper.
package gray_area_package;

    typedef enum logic {
        SCRUB_IDLE = 1'b0,
        SCRUB_REQ  = 1'b1
    } scrub_state_e;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_CORR   = 2'd1;
    localparam logic [1:0] ERR_UNCORR = 2'd2;

    // Smallest r with 2^r >= k + r + 1, i.e. enough bits to name any codeword bit.
    function automatic int hamming_address_width(input int data_width);
        int r;
        r = 1;
        while ((1 << r) < data_width + r + 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/hamming_error_monitor_if.sv
// Decoder-side stream, downstream stream and scrub write-back request of the
// error monitor, bundled as one interface.
interface hamming_error_monitor_if
    import gray_area_package::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int WORD_ADDR_WIDTH = 10
);
    localparam int ADDR_WIDTH = hamming_address_width(DATA_WIDTH);

    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [WORD_ADDR_WIDTH-1:0] in_addr_i;
    logic [DATA_WIDTH-1:0]      data_i;
    logic [ADDR_WIDTH-1:0]      fault_location_i;
    logic [1:0]                 num_errors_i;

    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [DATA_WIDTH-1:0]      out_data_o;
    logic [WORD_ADDR_WIDTH-1:0] out_addr_o;
    logic                       out_err_o;

    logic                       scrub_req_o;
    logic                       scrub_ack_i;
    logic [WORD_ADDR_WIDTH-1:0] scrub_addr_o;
    logic [DATA_WIDTH-1:0]      scrub_data_o;

    modport master (
        output in_valid_i, in_addr_i, data_i, fault_location_i, num_errors_i,
        output out_ready_i, scrub_ack_i,
        input  in_ready_o, out_valid_o, out_data_o, out_addr_o, out_err_o,
        input  scrub_req_o, scrub_addr_o, scrub_data_o
    );

    modport slave (
        input  in_valid_i, in_addr_i, data_i, fault_location_i, num_errors_i,
        input  out_ready_i, scrub_ack_i,
        output in_ready_o, out_valid_o, out_data_o, out_addr_o, out_err_o,
        output scrub_req_o, scrub_addr_o, scrub_data_o
    );

endinterface

// File: rtl/hamming_error_monitor_sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment restarts at 1
// so the event that arrived with the clear is not lost.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? WIDTH'(1) : '0;
        end else if (inc_i && !(&count_q)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/hamming_error_monitor.sv
// Post-decoder monitor: one-deep pipeline of decoded words, error statistics,
// sticky interrupt and single-entry scrub write-back request.
//   state      | meaning
//   SCRUB_IDLE | no write-back outstanding
//   SCRUB_REQ  | corrected word held on scrub_*, waiting for scrub_ack_i
module hamming_error_monitor
    import gray_area_package::*;
#(
    parameter  int DATA_WIDTH      = 32,
    parameter  int WORD_ADDR_WIDTH = 10,
    parameter  int CNT_WIDTH       = 16,
    localparam int ADDR_WIDTH      = hamming_address_width(DATA_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    hamming_error_monitor_if.slave     bus,
    input  logic [CNT_WIDTH-1:0]       threshold_i,
    input  logic                       irq_clear_i,
    output logic                       irq_o,
    output logic [CNT_WIDTH-1:0]       corr_count_o,
    output logic [CNT_WIDTH-1:0]       uncorr_count_o,
    output logic [CNT_WIDTH-1:0]       scrub_drop_o,
    output logic [ADDR_WIDTH-1:0]      last_fault_loc_o,
    output logic [WORD_ADDR_WIDTH-1:0] last_fault_addr_o
);

    logic                       out_valid_q;
    logic [DATA_WIDTH-1:0]      out_data_q;
    logic [WORD_ADDR_WIDTH-1:0] out_addr_q;
    logic                       out_err_q;

    scrub_state_e               state_q, state_d;
    logic [WORD_ADDR_WIDTH-1:0] scrub_addr_q, scrub_addr_d;
    logic [DATA_WIDTH-1:0]      scrub_data_q, scrub_data_d;
    logic                       drop_inc;

    logic                       irq_q, irq_d, irq_set;
    logic [CNT_WIDTH-1:0]       corr_next;
    logic [ADDR_WIDTH-1:0]      last_loc_q;
    logic [WORD_ADDR_WIDTH-1:0] last_addr_q;

    logic accept, is_corr, is_uncorr, is_fault;

    assign bus.in_ready_o = !out_valid_q || bus.out_ready_i;
    assign accept         = bus.in_valid_i && bus.in_ready_o;
    assign is_corr        = accept && (bus.num_errors_i == ERR_CORR);
    assign is_uncorr      = accept && (bus.num_errors_i >= ERR_UNCORR);
    assign is_fault       = accept && (bus.num_errors_i != ERR_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.data_i;
            out_addr_q  <= bus.in_addr_i;
            out_err_q   <= (bus.num_errors_i >= ERR_UNCORR);
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    // A corrected word arriving with the ack takes over the freed slot.
    always_comb begin
        state_d      = state_q;
        scrub_addr_d = scrub_addr_q;
        scrub_data_d = scrub_data_q;
        drop_inc     = 1'b0;
        case (state_q)
            SCRUB_IDLE: begin
                if (is_corr) begin
                    state_d      = SCRUB_REQ;
                    scrub_addr_d = bus.in_addr_i;
                    scrub_data_d = bus.data_i;
                end
            end
            SCRUB_REQ: begin
                if (bus.scrub_ack_i) begin
                    if (is_corr) begin
                        scrub_addr_d = bus.in_addr_i;
                        scrub_data_d = bus.data_i;
                    end else begin
                        state_d = SCRUB_IDLE;
                    end
                end else if (is_corr) begin
                    drop_inc = 1'b1;
                end
            end
            default: state_d = SCRUB_IDLE;
        endcase
    end

    // Value corr_count takes this cycle if a corrected word is accepted.
    always_comb begin
        if (irq_clear_i)         corr_next = CNT_WIDTH'(1);
        else if (&corr_count_o)  corr_next = corr_count_o;
        else                     corr_next = corr_count_o + CNT_WIDTH'(1);
    end

    assign irq_set = is_uncorr ||
                     (is_corr && (threshold_i != '0) && (corr_next >= threshold_i));
    assign irq_d   = irq_clear_i ? irq_set : (irq_q || irq_set);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SCRUB_IDLE;
            scrub_addr_q <= '0;
            scrub_data_q <= '0;
            irq_q        <= 1'b0;
            last_loc_q   <= '0;
            last_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            scrub_addr_q <= scrub_addr_d;
            scrub_data_q <= scrub_data_d;
            irq_q        <= irq_d;
            if (is_fault) begin
                last_loc_q  <= bus.fault_location_i;
                last_addr_q <= bus.in_addr_i;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_corr_cnt (
        .clk(clk), .rst(rst), .inc_i(is_corr), .clr_i(irq_clear_i), .count_o(corr_count_o)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_uncorr_cnt (
        .clk(clk), .rst(rst), .inc_i(is_uncorr), .clr_i(irq_clear_i), .count_o(uncorr_count_o)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk(clk), .rst(rst), .inc_i(drop_inc), .clr_i(irq_clear_i), .count_o(scrub_drop_o)
    );

    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_data_o   = out_data_q;
    assign bus.out_addr_o   = out_addr_q;
    assign bus.out_err_o    = out_err_q;
    assign bus.scrub_req_o  = (state_q == SCRUB_REQ);
    assign bus.scrub_addr_o = scrub_addr_q;
    assign bus.scrub_data_o = scrub_data_q;
    assign irq_o            = irq_q;
    assign last_fault_loc_o  = last_loc_q;
    assign last_fault_addr_o = last_addr_q;

endmodule
